// File: rtl/tinyqv_slice_pkg.sv
// -----------------------------------------------------------------------------
// tinyqv_slice_pkg
// Shared definitions for the slice sequencer: FSM state encoding and the
// helpers that derive slice count / slice counter width from the data and
// slice widths.
// -----------------------------------------------------------------------------
package tinyqv_slice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of slices in one operand.
    function automatic int calc_nslice(input int data_w, input int slice_w);
        return data_w / slice_w;
    endfunction

    // Width of the slice index counter.
    function automatic int calc_cnt_w(input int data_w, input int slice_w);
        return $clog2(data_w / slice_w);
    endfunction

endpackage

// File: rtl/tinyqv_slice_shreg.sv
// -----------------------------------------------------------------------------
// tinyqv_slice_shreg
// Per-channel parallel-load slice shift register. The operand is loaded in
// parallel and rotated right by one slice per shift, so after a full pass it
// is back in its loaded position and o_slice again shows slice 0. A parallel
// copy of the operand allows an aborted pass to snap back to slice 0.
//
// Ports:
//   clk, rstn   clock, async active-low reset
//   i_load      parallel load of i_data (operand accept)
//   i_shift     advance by one slice (RUN cycle)
//   i_restore   return to the loaded operand (abort)
//   i_data      operand
//   o_slice     current (lowest) slice
// -----------------------------------------------------------------------------
module tinyqv_slice_shreg #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic               i_restore,
    input  logic [DATA_W-1:0]  i_data,
    output logic [SLICE_W-1:0] o_slice
);

    logic [DATA_W-1:0] r_op;
    logic [DATA_W-1:0] r_sh;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op <= '0;
            r_sh <= '0;
        end else if (i_load) begin
            r_op <= i_data;
            r_sh <= i_data;
        end else if (i_restore) begin
            r_sh <= r_op;
        end else if (i_shift) begin
            // rotate so the operand returns to slice 0 after NSLICE shifts
            r_sh <= {r_sh[SLICE_W-1:0], r_sh[DATA_W-1:SLICE_W]};
        end
    end

    assign o_slice = r_sh[SLICE_W-1:0];

endmodule

// File: rtl/tinyqv_slice_seq.sv
// -----------------------------------------------------------------------------
// tinyqv_slice_seq
// Serialises N_CH operands slice by slice (LSB slice first) to a consumer,
// collects the consumer's result slice each cycle and presents the assembled
// result with a valid/ready handshake. Fixed latency: accept at T, RUN for
// T+1..T+NSLICE, out_valid from T+NSLICE+1. Back-to-back accept from DONE.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   in_valid/in_ready/in_data operand set handshake (channel c at c*DATA_W)
//   abort                     cancel the operation in RUN
//   slice_out                 current slice per channel
//   slice_idx                 current slice index
//   slice_active/first/last   RUN-cycle flags
//   res_slice_in              consumer result slice for the current index
//   out_valid/out_ready       result handshake
//   out_data                  assembled result
// -----------------------------------------------------------------------------
module tinyqv_slice_seq
    import tinyqv_slice_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 4,
    parameter int N_CH    = 3,
    localparam int NSLICE = calc_nslice(DATA_W, SLICE_W),
    localparam int CNT_W  = calc_cnt_w(DATA_W, SLICE_W)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*DATA_W-1:0]  in_data,
    input  logic                    abort,
    output logic [N_CH*SLICE_W-1:0] slice_out,
    output logic [CNT_W-1:0]        slice_idx,
    output logic                    slice_active,
    output logic                    slice_first,
    output logic                    slice_last,
    input  logic [SLICE_W-1:0]      res_slice_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSLICE - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_res;
    logic               w_accept;
    logic               w_last;
    logic               w_run;
    logic               w_shift;
    logic               w_restore;

    assign w_run     = (r_state == ST_RUN);
    assign w_last    = (r_idx == LAST_IDX);
    assign w_accept  = in_valid & in_ready;
    assign w_shift   = w_run & ~abort;
    assign w_restore = w_run & abort;

    // ---------------- operand shift registers ----------------
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        tinyqv_slice_shreg #(
            .DATA_W  (DATA_W),
            .SLICE_W (SLICE_W)
        ) u_shreg (
            .clk       (clk),
            .rstn      (rstn),
            .i_load    (w_accept),
            .i_shift   (w_shift),
            .i_restore (w_restore),
            .i_data    (in_data[c*DATA_W +: DATA_W]),
            .o_slice   (slice_out[c*SLICE_W +: SLICE_W])
        );
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_RUN;
            ST_RUN: begin
                // abort wins over the final slice
                if (abort)       w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
            end
            ST_DONE: if (out_ready) w_next = in_valid ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        slice_active = 1'b0;
        slice_first  = 1'b0;
        slice_last   = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN: begin
                slice_active = 1'b1;
                slice_first  = (r_idx == '0);
                slice_last   = w_last;
            end
            ST_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // ---------------- slice index ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (w_run) begin
            if (abort || w_last) r_idx <= '0;
            else                 r_idx <= r_idx + CNT_W'(1);
        end
    end

    // ---------------- result assembly ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res <= '0;
        end else if (w_run && !abort) begin
            for (int s = 0; s < NSLICE; s++) begin
                if (r_idx == CNT_W'(s)) r_res[s*SLICE_W +: SLICE_W] <= res_slice_in;
            end
        end
    end

    assign slice_idx = r_idx;
    assign out_data  = r_res;

endmodule

// File: tb/tb_tinyqv_slice_seq.sv
module tb_tinyqv_slice_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT with default params (SLICE_W=4), loopback ch0 ----------------
    logic        rstn4, v4, a4, ro4;
    logic [95:0] di4;
    logic        rdy4, act4, fst4, lst4, ov4;
    logic [11:0] so4;
    logic [2:0]  idx4;
    logic [3:0]  res4;
    logic [31:0] od4;

    assign res4 = so4[3:0];

    tinyqv_slice_seq u_dut4 (
        .clk(clk), .rstn(rstn4), .in_valid(v4), .in_ready(rdy4), .in_data(di4),
        .abort(a4), .slice_out(so4), .slice_idx(idx4), .slice_active(act4),
        .slice_first(fst4), .slice_last(lst4), .res_slice_in(res4),
        .out_valid(ov4), .out_ready(ro4), .out_data(od4)
    );

    // ---------------- DUT with SLICE_W=8, inverted ch1 loopback ----------------
    logic        rstn8, v8, a8, ro8;
    logic [95:0] di8;
    logic        rdy8, act8, fst8, lst8, ov8;
    logic [23:0] so8;
    logic [1:0]  idx8;
    logic [7:0]  res8;
    logic [31:0] od8;

    assign res8 = ~so8[15:8];

    tinyqv_slice_seq #(.DATA_W(32), .SLICE_W(8), .N_CH(3)) u_dut8 (
        .clk(clk), .rstn(rstn8), .in_valid(v8), .in_ready(rdy8), .in_data(di8),
        .abort(a8), .slice_out(so8), .slice_idx(idx8), .slice_active(act8),
        .slice_first(fst8), .slice_last(lst8), .res_slice_in(res8),
        .out_valid(ov8), .out_ready(ro8), .out_data(od8)
    );

    // ---------------- muxed view of the selected DUT ----------------
    bit          sel = 1'b0;
    logic        m_rdy, m_act, m_fst, m_lst, m_ov;
    logic [7:0]  m_slice;
    logic [2:0]  m_idx;
    logic [31:0] m_od;

    assign m_rdy   = sel ? rdy8 : rdy4;
    assign m_act   = sel ? act8 : act4;
    assign m_fst   = sel ? fst8 : fst4;
    assign m_lst   = sel ? lst8 : lst4;
    assign m_ov    = sel ? ov8  : ov4;
    assign m_slice = sel ? so8[15:8] : {4'b0, so4[3:0]};
    assign m_idx   = sel ? {1'b0, idx8} : idx4;
    assign m_od    = sel ? od8 : od4;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Full operation on the selected DUT; call just after a falling edge.
    task automatic run_op(input bit s, input logic [31:0] op, input logic [31:0] exp);
        int ns;
        logic [7:0] es;
        ns  = s ? 4 : 8;
        sel = s;
        if (s) begin
            di8 = {32'hCAFE0001, op, 32'h0}; v8 = 1'b1;
        end else begin
            di4 = {32'h0F0F0F0F, 32'h33333333, op}; v4 = 1'b1;
        end
        #1 chk("in_ready_idle", m_rdy, 1);
        @(negedge clk);
        v4 = 1'b0; v8 = 1'b0;
        for (int k = 0; k < ns; k++) begin
            es = s ? op[k*8 +: 8] : {4'b0, op[k*4 +: 4]};
            chk("run_slice", m_slice, es);
            chk("run_idx", m_idx, k);
            chk("run_active", m_act, 1);
            chk("run_first", m_fst, (k == 0));
            chk("run_last", m_lst, (k == ns-1));
            chk("run_no_valid", m_ov, 0);
            chk("run_in_ready", m_rdy, 0);
            @(negedge clk);
        end
        chk("done_valid", m_ov, 1);
        chk("done_data", m_od, exp);
        chk("done_active", m_act, 0);
        if (s) ro8 = 1'b1; else ro4 = 1'b1;
        @(negedge clk);
        ro4 = 1'b0; ro8 = 1'b0;
        chk("idle_valid", m_ov, 0);
        chk("idle_in_ready", m_rdy, 1);
    endtask

    typedef struct {
        bit          s;
        logic [31:0] op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 32'h12345678, 32'h12345678};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[2] = '{1'b0, 32'h00000000, 32'h00000000};
        vecs[3] = '{1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 32'hA5A50F0F, 32'h5A5AF0F0};
        vecs[5] = '{1'b1, 32'h00FF1234, 32'hFF00EDCB};

        rstn4 = 1'b0; rstn8 = 1'b0;
        v4 = 0; a4 = 0; ro4 = 0; di4 = '0;
        v8 = 0; a8 = 0; ro8 = 0; di8 = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst4_in_ready", rdy4, 1);
        chk("rst4_valid", ov4, 0);
        chk("rst4_flags", {act4, fst4, lst4}, 0);
        chk("rst4_idx", idx4, 0);
        chk("rst4_slice", so4, 0);
        chk("rst4_data", od4, 0);
        chk("rst8_valid", ov8, 0);
        chk("rst8_idx", idx8, 0);
        chk("rst8_slice", so8, 0);

        // first accept on the first rising edge after release
        rstn4 = 1'b1; rstn8 = 1'b1;
        for (int i = 0; i < 6; i++) run_op(vecs[i].s, vecs[i].op, vecs[i].exp);

        // outside RUN, slice_out shows slice 0 of the loaded operands (all channels)
        sel = 1'b0;
        chk("idle_slice_ch0", so4[3:0], 4'hF);
        chk("idle_slice_ch2", so4[11:8], 4'hF);

        // backpressure in DONE, abort ignored there, then zero-bubble accept
        di4 = {32'h0, 32'h0, 32'hCAFEBABE}; v4 = 1'b1;
        @(negedge clk); v4 = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", ov4, 1);
            chk("bp_data", od4, 32'hCAFEBABE);
            chk("bp_in_ready", rdy4, 0);
            a4 = (i == 2);
            @(negedge clk);
            a4 = 1'b0;
        end
        ro4 = 1'b1; v4 = 1'b1; di4 = {32'h0, 32'h0, 32'h13579BDF};
        #1 chk("bp_in_ready_on_ready", rdy4, 1);
        @(negedge clk);
        v4 = 1'b0; ro4 = 1'b0;
        chk("b2b_first", fst4, 1);
        chk("b2b_active", act4, 1);
        chk("b2b_valid", ov4, 0);
        chk("b2b_slice", so4[3:0], 4'hF);
        repeat (8) @(negedge clk);
        chk("b2b_done_valid", ov4, 1);
        chk("b2b_done_data", od4, 32'h13579BDF);
        ro4 = 1'b1; @(negedge clk); ro4 = 1'b0;

        // abort at slice 3
        di4 = {32'h0, 32'h0, 32'h89ABCDEF}; v4 = 1'b1;
        @(negedge clk); v4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_at_idx", idx4, 3);
        a4 = 1'b1;
        @(negedge clk);
        a4 = 1'b0;
        chk("abort_in_ready", rdy4, 1);
        chk("abort_active", act4, 0);
        chk("abort_idx", idx4, 0);
        chk("abort_slice0", so4[3:0], 4'hF);
        for (int i = 0; i < 10; i++) begin
            chk("abort_no_valid", ov4, 0);
            @(negedge clk);
        end
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // async reset mid-RUN
        di4 = {32'h0, 32'h0, 32'h2468ACE0}; v4 = 1'b1;
        @(negedge clk); v4 = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_at_idx", idx4, 5);
        #2 rstn4 = 1'b0;
        #1;
        chk("arst_valid", ov4, 0);
        chk("arst_idx", idx4, 0);
        chk("arst_flags", {act4, fst4, lst4}, 0);
        chk("arst_in_ready", rdy4, 1);
        chk("arst_data", od4, 0);
        chk("arst_slice", so4, 0);
        @(negedge clk);
        rstn4 = 1'b1;
        run_op(1'b0, 32'h0BADF00D, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tinyqv_slice_seq.md
TINYQV_SLICE_SEQ -- requirements
Module: tinyqv_slice_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the parallel operand/result width in bits.
REQ-002 SHALL have parameter SLICE_W, default 4, giving the bits per serial slice; legal values are 1, 2, 4 and 8; DATA_W is a multiple of SLICE_W.
REQ-003 SHALL have parameter N_CH, default 3, giving the number of operand channels serialised in parallel.
REQ-004 SHALL derive NSLICE = DATA_W/SLICE_W (at least 2) and CNT_W = clog2(NSLICE).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: operand set offered.
REQ-008 SHALL have port in_ready, output, 1 bit: operand set accepted when in_valid & in_ready.
REQ-009 SHALL have port in_data, input, N_CH*DATA_W bits: channel c occupies [c*DATA_W +: DATA_W].
REQ-010 SHALL have port abort, input, 1 bit: cancels the operation in flight.
REQ-011 SHALL have port slice_out, output, N_CH*SLICE_W bits: current slice of each channel.
REQ-012 SHALL have port slice_idx, output, CNT_W bits: index of the current slice, LSB slice first.
REQ-013 SHALL have ports slice_active, slice_first and slice_last, outputs, 1 bit each: RUN-state cycle flags.
REQ-014 SHALL have port res_slice_in, input, SLICE_W bits: result slice returned by the consumer in the same cycle.
REQ-015 SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: result handshake.
REQ-016 SHALL have port out_data, output, DATA_W bits: the assembled result.

Function
REQ-017 SHALL implement the states IDLE, RUN and DONE.
REQ-018 in_ready SHALL be 1 in IDLE, 0 in RUN, and equal to out_ready in DONE.
REQ-019 On accept, SHALL load all channels into per-channel shift registers, set slice_idx to 0 and enter RUN on the next cycle.
REQ-020 In RUN, slice_out for channel c SHALL equal operand bits [slice_idx*SLICE_W +: SLICE_W].
REQ-021 In RUN, slice_active SHALL be 1, slice_first SHALL be 1 when idx is 0, and slice_last SHALL be 1 when idx is NSLICE-1.
REQ-022 In RUN, each cycle SHALL capture res_slice_in into result bits [slice_idx*SLICE_W +: SLICE_W] and increment slice_idx.
REQ-023 On the slice_last cycle, slice_idx SHALL wrap to 0 and the state SHALL go to DONE.
REQ-024 Latency SHALL be fixed: accept at cycle T gives RUN for cycles T+1 to T+NSLICE and out_valid at T+NSLICE+1.
REQ-025 In DONE, out_valid SHALL be 1 and out_data SHALL hold the full result, stable until out_ready.
REQ-026 In DONE with out_ready=1 and in_valid=0, SHALL return to IDLE.
REQ-027 In DONE with out_ready=1 and in_valid=1, SHALL accept the new operand set in the same cycle and go directly to RUN (zero-bubble back-to-back).
REQ-028 abort in RUN SHALL force IDLE next cycle, discard the partial result, produce no out_valid, and take priority over slice_last.
REQ-029 abort in IDLE or DONE SHALL be ignored.
REQ-030 Outside RUN, slice_active, slice_first and slice_last SHALL be 0, and slice_out SHALL present slice 0 of the loaded operands.
REQ-031 out_data SHALL not change outside DONE except on result capture in RUN; out_data is undefined-but-stable outside DONE.

Reset
REQ-032 rstn low SHALL asynchronously force IDLE, slice_idx=0, out_valid=0, in_ready=1 after release, all flags 0, and shift and result registers 0.
REQ-033 Reset asserted mid-RUN or mid-DONE SHALL lose the operation with no out_valid.
REQ-034 After rstn deasserts, the first accept is possible on the first rising edge.

Structure
REQ-035 State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NSLICE/CNT_W helper function SHALL live in shared package tinyqv_slice_pkg.
REQ-036 The per-channel parallel-load, slice-shift register SHALL be sub-module tinyqv_slice_shreg, instantiated N_CH times via generate.
REQ-037 The FSM, counter and result assembly SHALL reside in tinyqv_slice_seq.

Verification
REQ-038 Loopback (res_slice_in = channel-0 slice_out), default params: in_data ch0=0x12345678 accepted at T -> slice_out ch0 = 8,7,6,5,4,3,2,1 at T+1 to T+8, out_valid at T+9, out_data=0x12345678.
REQ-039 SLICE_W=8, DATA_W=32, res_slice_in = ~slice_out ch1: ch1=0xA5A5_0F0F -> 4 RUN cycles, out_valid at T+5, out_data=0x5A5A_F0F0.
REQ-040 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data held, in_ready=0; on out_ready=1 with in_valid=1 -> new accept and RUN next cycle with slice_first=1.
REQ-041 Abort: abort=1 at slice_idx=3 -> IDLE next cycle, in_ready=1, out_valid stays 0; next operation 0xFFFFFFFF loops back correctly.
REQ-042 Reset: rstn low at slice_idx=5 -> outputs at reset values immediately (async); after release, a full operation completes with 9-cycle latency.
